// File: rtl/vga_pkg.sv
// Shared constants, types and small arithmetic helpers for the 640x480 air-hockey engine.
package vga_pkg;

    typedef logic signed [10:0] coord_t;

    typedef struct packed {
        logic [2:0] r;
        logic [2:0] g;
        logic [1:0] b;
    } rgb_t;

    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StPlay    = 2'd1,
        StPause   = 2'd2,
        StIdleAlt = 2'd3
    } game_state_e;

    localparam logic [9:0] H_ACTIVE     = 10'd640;
    localparam logic [9:0] H_SYNC_START = 10'd656;
    localparam logic [9:0] H_SYNC_END   = 10'd751;
    localparam logic [9:0] H_TOTAL      = 10'd800;
    localparam logic [9:0] V_ACTIVE     = 10'd480;
    localparam logic [9:0] V_SYNC_START = 10'd490;
    localparam logic [9:0] V_SYNC_END   = 10'd491;
    localparam logic [9:0] V_TOTAL      = 10'd525;

    localparam coord_t MALLET_HALF = 11'sd8;
    localparam coord_t PUCK_HALF   = 11'sd4;
    localparam coord_t COLLIDE_R   = 11'sd12;

    localparam logic [9:0] JOY_LO = 10'd448;
    localparam logic [9:0] JOY_HI = 10'd575;
    localparam coord_t     STEP   = 11'sd2;

    localparam coord_t M1_X0   = 11'sd160;
    localparam coord_t M1_Y0   = 11'sd240;
    localparam coord_t M2_X0   = 11'sd480;
    localparam coord_t M2_Y0   = 11'sd240;
    localparam coord_t PUCK_X0 = 11'sd320;
    localparam coord_t PUCK_Y0 = 11'sd240;

    localparam coord_t M1_X_MIN = 11'sd8;
    localparam coord_t M1_X_MAX = 11'sd311;
    localparam coord_t M2_X_MIN = 11'sd328;
    localparam coord_t M2_X_MAX = 11'sd631;
    localparam coord_t M_Y_MIN  = 11'sd8;
    localparam coord_t M_Y_MAX  = 11'sd471;
    localparam coord_t P_MIN    = 11'sd4;
    localparam coord_t P_X_MAX  = 11'sd635;
    localparam coord_t P_Y_MAX  = 11'sd475;

    localparam logic [9:0] CENTRE_L = 10'd319;
    localparam logic [9:0] CENTRE_R = 10'd320;

    localparam rgb_t RGB_BLACK = 8'b000_000_00;
    localparam rgb_t RGB_WHITE = 8'b111_111_11;
    localparam rgb_t RGB_RED   = 8'b111_000_00;
    localparam rgb_t RGB_BLUE  = 8'b000_000_11;

    function automatic coord_t abs_c(input coord_t v);
        return v[10] ? -v : v;
    endfunction

    function automatic coord_t clamp_c(input coord_t v, input coord_t lo, input coord_t hi);
        if (v < lo) return lo;
        if (v > hi) return hi;
        return v;
    endfunction

    // Joystick y is inverted: pushing up (high reading) moves the mallet towards row 0.
    function automatic coord_t joy_step(input logic [9:0] j, input logic invert);
        coord_t s;
        s = '0;
        if (j > JOY_HI)      s = STEP;
        else if (j < JOY_LO) s = -STEP;
        return invert ? -s : s;
    endfunction

    function automatic coord_t bounce_dir(input coord_t p, input coord_t m, input coord_t v);
        if (p > m) return STEP;
        if (p < m) return -STEP;
        return v;
    endfunction

endpackage

// File: rtl/vga_timing.sv
// 25 MHz pixel enable, 800x525 raster counters, registered syncs and the end-of-frame tick.
module vga_timing
    import vga_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    output logic       pe,
    output logic [9:0] hc,
    output logic [9:0] vc,
    output logic       active,
    output logic       hsync,
    output logic       vsync,
    output logic       frame_tick
);

    logic [1:0] div_q;
    logic [9:0] hc_q, hc_d;
    logic [9:0] vc_q, vc_d;
    logic       hsync_q, vsync_q;

    assign pe = (div_q == 2'd3);

    always_comb begin
        hc_d = hc_q;
        vc_d = vc_q;
        if (pe) begin
            if (hc_q == H_TOTAL - 10'd1) begin
                hc_d = '0;
                vc_d = (vc_q == V_TOTAL - 10'd1) ? '0 : vc_q + 10'd1;
            end else begin
                hc_d = hc_q + 10'd1;
            end
        end
    end

    // Counters load every clk (holding between enables) so their value is always hc_d/vc_d.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_q   <= '0;
            hc_q    <= '0;
            vc_q    <= '0;
            hsync_q <= 1'b1;
            vsync_q <= 1'b1;
        end else begin
            div_q <= div_q + 2'd1;
            hc_q  <= hc_d;
            vc_q  <= vc_d;
            if (pe) begin
                hsync_q <= !((hc_q >= H_SYNC_START) && (hc_q <= H_SYNC_END));
                vsync_q <= !((vc_q >= V_SYNC_START) && (vc_q <= V_SYNC_END));
            end
        end
    end

    assign hc         = hc_q;
    assign vc         = vc_q;
    assign hsync      = hsync_q;
    assign vsync      = vsync_q;
    assign active     = (hc_q < H_ACTIVE) && (vc_q < V_ACTIVE);
    assign frame_tick = pe && (hc_q == H_TOTAL - 10'd1) && (vc_q == V_ACTIVE - 10'd1);

endmodule

// File: rtl/vga_640x480.sv
// Air-hockey game engine: per-frame mallet/puck physics and the registered pixel colour mux.
module vga_640x480
    import vga_pkg::*;
(
    input  logic       clk,
    input  logic       clr,
    input  logic [9:0] joy_x_1,
    input  logic [9:0] joy_y_1,
    input  logic [9:0] joy_x_2,
    input  logic [9:0] joy_y_2,
    input  logic [1:0] state,
    output logic       hsync,
    output logic       vsync,
    output logic [2:0] red,
    output logic [2:0] green,
    output logic [1:0] blue,
    output logic [9:0] dot_x_1,
    output logic [9:0] dot_y_1,
    output logic [9:0] dot_x_2,
    output logic [9:0] dot_y_2,
    output logic [9:0] puck_x,
    output logic [9:0] puck_y,
    output logic       collide1,
    output logic       collide2
);

    logic       pe, active, frame_tick;
    logic [9:0] hc, vc;

    vga_timing u_timing (
        .clk        (clk),
        .rst_n      (clr),
        .pe         (pe),
        .hc         (hc),
        .vc         (vc),
        .active     (active),
        .hsync      (hsync),
        .vsync      (vsync),
        .frame_tick (frame_tick)
    );

    game_state_e st;
    assign st = game_state_e'(state);

    coord_t m1x_q, m1y_q, m2x_q, m2y_q, px_q, py_q, vx_q, vy_q;
    coord_t m1x_d, m1y_d, m2x_d, m2y_d, px_d, py_d, vx_d, vy_d;
    logic   c1_q, c2_q, c1_d, c2_d;

    coord_t p_m1x, p_m1y, p_m2x, p_m2y, p_px, p_py, p_vx, p_vy;
    logic   p_c1, p_c2;

    always_comb begin
        p_m1x = clamp_c(m1x_q + joy_step(joy_x_1, 1'b0), M1_X_MIN, M1_X_MAX);
        p_m1y = clamp_c(m1y_q + joy_step(joy_y_1, 1'b1), M_Y_MIN, M_Y_MAX);
        p_m2x = clamp_c(m2x_q + joy_step(joy_x_2, 1'b0), M2_X_MIN, M2_X_MAX);
        p_m2y = clamp_c(m2y_q + joy_step(joy_y_2, 1'b1), M_Y_MIN, M_Y_MAX);
        p_px  = px_q + vx_q;
        p_py  = py_q + vy_q;
        p_c1  = (abs_c(p_px - p_m1x) < COLLIDE_R) && (abs_c(p_py - p_m1y) < COLLIDE_R);
        p_c2  = (abs_c(p_px - p_m2x) < COLLIDE_R) && (abs_c(p_py - p_m2y) < COLLIDE_R);
        p_vx  = vx_q;
        p_vy  = vy_q;
        if (p_c1) begin
            p_vx = STEP;
            p_vy = bounce_dir(p_py, p_m1y, p_vy);
        end
        if (p_c2) begin
            p_vx = -STEP;
            p_vy = bounce_dir(p_py, p_m2y, p_vy);
        end
        // Walls are resolved last so they override any mallet deflection on their axis.
        if (p_px <= P_MIN) begin
            p_px = P_MIN;
            p_vx = STEP;
        end else if (p_px >= P_X_MAX) begin
            p_px = P_X_MAX;
            p_vx = -STEP;
        end
        if (p_py <= P_MIN) begin
            p_py = P_MIN;
            p_vy = STEP;
        end else if (p_py >= P_Y_MAX) begin
            p_py = P_Y_MAX;
            p_vy = -STEP;
        end
    end

    always_comb begin
        m1x_d = m1x_q;
        m1y_d = m1y_q;
        m2x_d = m2x_q;
        m2y_d = m2y_q;
        px_d  = px_q;
        py_d  = py_q;
        vx_d  = vx_q;
        vy_d  = vy_q;
        c1_d  = c1_q;
        c2_d  = c2_q;
        if (frame_tick) begin
            unique case (st)
                StIdle, StIdleAlt: begin
                    m1x_d = M1_X0;
                    m1y_d = M1_Y0;
                    m2x_d = M2_X0;
                    m2y_d = M2_Y0;
                    px_d  = PUCK_X0;
                    py_d  = PUCK_Y0;
                    vx_d  = STEP;
                    vy_d  = STEP;
                    c1_d  = 1'b0;
                    c2_d  = 1'b0;
                end
                StPlay: begin
                    m1x_d = p_m1x;
                    m1y_d = p_m1y;
                    m2x_d = p_m2x;
                    m2y_d = p_m2y;
                    px_d  = p_px;
                    py_d  = p_py;
                    vx_d  = p_vx;
                    vy_d  = p_vy;
                    c1_d  = p_c1;
                    c2_d  = p_c2;
                end
                StPause: begin
                end
            endcase
        end
    end

    coord_t hpos, vpos;
    logic   in_puck, in_m1, in_m2, in_centre;
    rgb_t   rgb_d, rgb_q;

    assign hpos      = coord_t'({1'b0, hc});
    assign vpos      = coord_t'({1'b0, vc});
    assign in_puck   = (abs_c(hpos - px_q) < PUCK_HALF) && (abs_c(vpos - py_q) < PUCK_HALF);
    assign in_m1     = (abs_c(hpos - m1x_q) <= MALLET_HALF) && (abs_c(vpos - m1y_q) <= MALLET_HALF);
    assign in_m2     = (abs_c(hpos - m2x_q) <= MALLET_HALF) && (abs_c(vpos - m2y_q) <= MALLET_HALF);
    assign in_centre = (hc >= CENTRE_L) && (hc <= CENTRE_R);

    always_comb begin
        rgb_d = RGB_BLACK;
        if (active) begin
            if (in_puck)        rgb_d = RGB_WHITE;
            else if (in_m1)     rgb_d = RGB_RED;
            else if (in_m2)     rgb_d = RGB_BLUE;
            else if (in_centre) rgb_d = RGB_WHITE;
        end
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            m1x_q <= M1_X0;
            m1y_q <= M1_Y0;
            m2x_q <= M2_X0;
            m2y_q <= M2_Y0;
            px_q  <= PUCK_X0;
            py_q  <= PUCK_Y0;
            vx_q  <= STEP;
            vy_q  <= STEP;
            c1_q  <= 1'b0;
            c2_q  <= 1'b0;
            rgb_q <= RGB_BLACK;
        end else begin
            m1x_q <= m1x_d;
            m1y_q <= m1y_d;
            m2x_q <= m2x_d;
            m2y_q <= m2y_d;
            px_q  <= px_d;
            py_q  <= py_d;
            vx_q  <= vx_d;
            vy_q  <= vy_d;
            c1_q  <= c1_d;
            c2_q  <= c2_d;
            if (pe) rgb_q <= rgb_d;
        end
    end

    assign red      = rgb_q.r;
    assign green    = rgb_q.g;
    assign blue     = rgb_q.b;
    assign dot_x_1  = m1x_q[9:0];
    assign dot_y_1  = m1y_q[9:0];
    assign dot_x_2  = m2x_q[9:0];
    assign dot_y_2  = m2y_q[9:0];
    assign puck_x   = px_q[9:0];
    assign puck_y   = py_q[9:0];
    assign collide1 = c1_q;
    assign collide2 = c2_q;

endmodule

// File: tb/tb_vga_640x480.sv
// Directed bench for vga_640x480; raster counters are jumped near points of interest to keep runs short.
module tb_vga_640x480;

    logic       clk = 1'b0;
    logic       clr = 1'b0;
    logic [9:0] joy_x_1, joy_y_1, joy_x_2, joy_y_2;
    logic [1:0] state;
    logic       hsync, vsync;
    logic [2:0] red, green;
    logic [1:0] blue;
    logic [9:0] dot_x_1, dot_y_1, dot_x_2, dot_y_2, puck_x, puck_y;
    logic       collide1, collide2;

    int         checks = 0;
    int         errors = 0;
    int         lo;
    logic [9:0] f_hc, f_vc;

    vga_640x480 dut (
        .clk      (clk),
        .clr      (clr),
        .joy_x_1  (joy_x_1),
        .joy_y_1  (joy_y_1),
        .joy_x_2  (joy_x_2),
        .joy_y_2  (joy_y_2),
        .state    (state),
        .hsync    (hsync),
        .vsync    (vsync),
        .red      (red),
        .green    (green),
        .blue     (blue),
        .dot_x_1  (dot_x_1),
        .dot_y_1  (dot_y_1),
        .dot_x_2  (dot_x_2),
        .dot_y_2  (dot_y_2),
        .puck_x   (puck_x),
        .puck_y   (puck_y),
        .collide1 (collide1),
        .collide2 (collide2)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Moves the raster to (h,v) across a non-enable edge, leaving one clk after a pixel enable.
    task automatic jump(input logic [9:0] h, input logic [9:0] v);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!dut.u_timing.pe && n < 8);
        @(posedge clk);
        #1;
        f_hc = h;
        f_vc = v;
        force dut.u_timing.hc_q = f_hc;
        force dut.u_timing.vc_q = f_vc;
        @(posedge clk);
        #1;
        release dut.u_timing.hc_q;
        release dut.u_timing.vc_q;
    endtask

    task automatic frames(input int n);
        repeat (n) begin
            jump(10'd795, 10'd479);
            repeat (24) @(posedge clk);
            #1;
        end
    endtask

    task automatic pixel(input string tag, input logic [9:0] h, input logic [9:0] v,
                         input logic [7:0] exp);
        jump(h, v);
        repeat (3) @(posedge clk);
        #1;
        check(tag, {red, green, blue}, exp);
    endtask

    task automatic puck_is(input string tag, input int x, input int y);
        check({tag, ".px"}, puck_x, x);
        check({tag, ".py"}, puck_y, y);
    endtask

    task automatic mallets_are(input string tag, input int x1, input int y1, input int x2,
                               input int y2);
        check({tag, ".m1x"}, dot_x_1, x1);
        check({tag, ".m1y"}, dot_y_1, y1);
        check({tag, ".m2x"}, dot_x_2, x2);
        check({tag, ".m2y"}, dot_y_2, y2);
    endtask

    initial begin
        joy_x_1 = 10'd512;
        joy_y_1 = 10'd512;
        joy_x_2 = 10'd512;
        joy_y_2 = 10'd512;
        state   = 2'd0;
        repeat (3) @(posedge clk);
        #1;
        check("rst.hsync", hsync, 1);
        check("rst.vsync", vsync, 1);
        check("rst.rgb", {red, green, blue}, 0);
        mallets_are("rst", 160, 240, 480, 240);
        puck_is("rst", 320, 240);
        check("rst.c1", collide1, 0);
        check("rst.c2", collide2, 0);

        @(negedge clk);
        clr = 1'b1;
        lo = 0;
        repeat (3200) begin
            @(negedge clk);
            if (!hsync) lo++;
        end
        check("hsync_low_clks", lo, 384);

        pixel("pix.puck", 10'd320, 10'd240, 8'hFF);
        pixel("pix.m1", 10'd163, 10'd247, 8'hE0);
        pixel("pix.m2", 10'd480, 10'd240, 8'h03);
        pixel("pix.centre", 10'd319, 10'd100, 8'hFF);
        pixel("pix.off_centre", 10'd321, 10'd100, 8'h00);
        pixel("pix.black", 10'd100, 10'd100, 8'h00);
        pixel("pix.hblank", 10'd700, 10'd100, 8'h00);
        pixel("pix.vblank", 10'd320, 10'd480, 8'h00);

        jump(10'd795, 10'd489);
        lo = 0;
        repeat (12800) begin
            @(negedge clk);
            if (!vsync) lo++;
        end
        check("vsync_low_clks", lo, 6400);

        state = 2'd1;
        frames(1);
        puck_is("play1", 322, 242);
        mallets_are("play1", 160, 240, 480, 240);
        check("play1.c1", collide1, 0);
        check("play1.c2", collide2, 0);
        state = 2'd0;
        frames(1);
        puck_is("idle_reload", 320, 240);

        state   = 2'd1;
        joy_x_1 = 10'd1023;
        frames(50);
        check("clamp.mid", dot_x_1, 260);
        frames(50);
        mallets_are("clamp.end", 311, 240, 480, 240);
        joy_x_1 = 10'd512;
        state   = 2'd0;
        frames(1);
        mallets_are("clamp.reload", 160, 240, 480, 240);

        // Mallet 1 goes to (300,390); mallet 2 tracks the puck down and knocks it back left.
        state   = 2'd1;
        joy_x_1 = 10'd1023;
        joy_y_1 = 10'd0;
        joy_y_2 = 10'd0;
        frames(70);
        check("traj70.m1x", dot_x_1, 300);
        check("traj70.m1y", dot_y_1, 380);
        joy_x_1 = 10'd512;
        frames(4);
        puck_is("f74", 468, 388);
        check("f74.c2", collide2, 0);
        frames(1);
        puck_is("f75", 470, 390);
        mallets_are("f75", 300, 390, 480, 390);
        check("f75.c2", collide2, 1);
        check("f75.c1", collide1, 0);
        joy_y_1 = 10'd512;
        joy_y_2 = 10'd512;
        frames(1);
        puck_is("f76", 468, 392);
        check("f76.c2", collide2, 0);
        frames(41);
        puck_is("f117", 386, 474);
        frames(1);
        puck_is("f118_wall", 384, 475);
        frames(1);
        puck_is("f119", 382, 473);
        frames(35);
        puck_is("f154", 312, 403);
        check("f154.c1", collide1, 0);
        frames(1);
        puck_is("f155", 310, 401);
        check("f155.c1", collide1, 1);
        check("f155.c2", collide2, 0);

        state = 2'd2;
        frames(3);
        puck_is("pause", 310, 401);
        mallets_are("pause", 300, 390, 480, 390);
        check("pause.c1", collide1, 1);
        state = 2'd1;
        frames(1);
        puck_is("f156", 312, 403);
        check("f156.c1", collide1, 0);

        pixel("pix.puck_live", 10'd312, 10'd403, 8'hFF);
        @(posedge clk);
        #1;
        clr = 1'b0;
        #1;
        check("arst.rgb", {red, green, blue}, 0);
        check("arst.hsync", hsync, 1);
        check("arst.vsync", vsync, 1);
        puck_is("arst", 320, 240);
        mallets_are("arst", 160, 240, 480, 240);
        check("arst.c1", collide1, 0);
        @(negedge clk);
        clr = 1'b1;

        jump(10'd700, 10'd100);
        repeat (8) @(posedge clk);
        #1;
        check("hsync_in_pulse", hsync, 0);
        clr = 1'b0;
        #1;
        check("arst_sync.hsync", hsync, 1);
        @(negedge clk);
        clr = 1'b1;

        state = 2'd1;
        frames(1);
        puck_is("replay", 322, 242);
        state = 2'd3;
        frames(1);
        puck_is("idle3_reload", 320, 240);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
